// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Write-port priority for bypass lives here so every read port resolves it identically.
package reg_file_mp_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  localparam rf_addr_t RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic hit;
    logic idx;
  } rf_fwd_t;

  // Port 1 outranks port 0, matching the write-collision rule in the array.
  function automatic rf_fwd_t rf_fwd(input logic [1:0] hit);
    rf_fwd_t r;
    r.hit = |hit;
    r.idx = hit[1];
    return r;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle between the pipeline (decode/writeback) and the register file.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2,
  parameter int N_WR   = 1
);
  logic [N_RD-1:0]        rd_en;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_valid;
  logic [N_RD-1:0]        rd_busy;
  logic [N_WR-1:0]        wr_en;
  logic [N_WR*ADDR_W-1:0] wr_addr;
  logic [N_WR*DATA_W-1:0] wr_data;
  logic                   alloc_en;
  logic [ADDR_W-1:0]      alloc_addr;
  logic [2**ADDR_W-1:0]   busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_valid, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_valid, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp_rf_scoreboard.sv
// Per-register pending bits: alloc sets, write clears, set wins on a same-cycle tie.
// Also exposes the post-clear/pre-alloc view that read ports report as rd_busy.
module rf_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2**ADDR_W-1:0] clr,
  input  logic                 alloc_en,
  input  logic [ADDR_W-1:0]    alloc_addr,
  output logic [2**ADDR_W-1:0] pend_cleared,
  output logic [2**ADDR_W-1:0] busy_vec
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] pending_next;

  always_comb begin
    set_vec      = '0;
    pend_cleared = pending & ~clr;
    if (alloc_en)
      set_vec[alloc_addr] = 1'b1;
    pending_next = pend_cleared | set_vec;
    if (ZERO_REG != 0) begin
      pend_cleared[0] = 1'b0;
      pending_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pending <= '0;
    else
      pending <= pending_next;
  end

  assign busy_vec = pending;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: clocked writes, registered reads with same-cycle bypass,
// optional hardwired zero register, and a pending-bit scoreboard for in-flight results.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  pend_cleared;
  logic [DATA_W-1:0] rd_next [N_RD];
  logic [N_RD-1:0]   busy_next;

  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .clr          (wr_hit),
    .alloc_en     (bus.alloc_en),
    .alloc_addr   (bus.alloc_addr),
    .pend_cleared (pend_cleared),
    .busy_vec     (bus.busy_vec)
  );

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < N_WR; w++)
      if (bus.wr_en[w])
        wr_hit[bus.wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
  end

  // Later write ports are applied last, so port 1 wins a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++)
        regs[k] <= '0;
    end else begin
      for (int w = 0; w < N_WR; w++)
        if (bus.wr_en[w] &&
            !(ZERO_REG != 0 && bus.wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(RF_ZERO_ADDR)))
          regs[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic [1:0]        hit;
    rf_fwd_t           fwd;
    for (int i = 0; i < N_RD; i++) begin
      addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
      hit  = '0;
      for (int w = 0; w < N_WR; w++)
        hit[w] = bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] == addr);
      fwd          = rf_fwd(hit);
      rd_next[i]   = regs[addr];
      busy_next[i] = pend_cleared[addr];
      if (BYPASS != 0 && fwd.hit)
        for (int w = 0; w < N_WR; w++)
          if (fwd.idx == 1'(w))
            rd_next[i] = bus.wr_data[w*DATA_W +: DATA_W];
      if (ZERO_REG != 0 && addr == ADDR_W'(RF_ZERO_ADDR))
        rd_next[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= '0;
      bus.rd_busy  <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++) begin
        bus.rd_valid[i] <= bus.rd_en[i];
        if (bus.rd_en[i]) begin
          bus.rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
          bus.rd_busy[i]                  <= busy_next[i];
        end
      end
    end
  end
endmodule
